pwr_iso_ctrl: RTL and testbench
===============================

PWR_ISO_CTRL -- requirements
Module: pwr_iso_ctrl

Interface
REQ-001 SHALL have parameter ISO_SETUP_CYC, default 4: cycles iso_en is held high before save/power-off.
REQ-002 SHALL have parameter ISO_HOLD_CYC, default 4: cycles iso_en is held high after restore/power-on.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 255: wait cycles for pwr_sw_ack before err is flagged.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is rising-edge clocked.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port pu_req, input, 1: power-up request level, sampled only in OFF.
REQ-007 SHALL have port pd_req, input, 1: power-down request level, sampled only in ON.
REQ-008 SHALL have port pwr_sw_en, output, 1: power-switch enable to the domain header.
REQ-009 SHALL have port pwr_sw_ack, input, 1: power-switch status, 1 = rail good; synchronous to clk.
REQ-010 SHALL have port iso_en, output, 1: isolation enable to clamp cells, 1 = clamped.
REQ-011 SHALL have port save, output, 1: one-cycle retention save pulse.
REQ-012 SHALL have port restore, output, 1: one-cycle retention restore pulse.
REQ-013 SHALL have port busy, output, 1: high in every state except ON and OFF.
REQ-014 SHALL have port done, output, 1: one-cycle pulse on entry to ON or OFF from a transition.
REQ-015 SHALL have port err, output, 1: sticky ack-timeout flag.
REQ-016 SHALL have port err_clr, input, 1: clears err.

Function
REQ-017 SHALL implement states OFF, PU_WAIT, RESTORE, ISO_HOLD, ON, ISO_SETUP, SAVE, PD_WAIT.
REQ-018 OFF: iso_en=1, pwr_sw_en=0; pu_req=1 -> PU_WAIT next cycle; pd_req ignored.
REQ-019 PU_WAIT: pwr_sw_en=1, iso_en=1; pwr_sw_ack=1 -> RESTORE.
REQ-020 RESTORE: restore=1 for exactly one cycle -> ISO_HOLD.
REQ-021 ISO_HOLD: iso_en=1 for exactly ISO_HOLD_CYC cycles -> ON; iso_en=0 from the first ON cycle.
REQ-022 ON: iso_en=0, pwr_sw_en=1; pd_req=1 -> ISO_SETUP next cycle; pu_req ignored; pd_req and pu_req both high -> power-down.
REQ-023 ISO_SETUP: iso_en=1 from its first cycle, held ISO_SETUP_CYC cycles -> SAVE.
REQ-024 SAVE: save=1 for exactly one cycle -> PD_WAIT.
REQ-025 PD_WAIT: pwr_sw_en=0, iso_en=1; pwr_sw_ack=0 -> OFF.
REQ-026 Requests arriving while busy=1 SHALL be ignored, not queued.
REQ-027 iso_en SHALL never be 0 while pwr_sw_en=0 or pwr_sw_ack=0.
REQ-028 A wait counter SHALL run in PU_WAIT/PD_WAIT; reaching ACK_TIMEOUT cycles without ack sets err; the FSM keeps waiting.
REQ-029 err_clr clears err next cycle; a timeout set in the same cycle wins.
REQ-030 All outputs SHALL be registered; done SHALL be high only in the first cycle of ON/OFF.

Reset
REQ-031 On rst_n=0, asynchronously: state=OFF, iso_en=1, pwr_sw_en=0, save=0, restore=0, busy=0, done=0, err=0, counters=0.
REQ-032 Reset mid-transition SHALL abandon the sequence with no save/restore pulse.

Configuration
REQ-033 With PWR_ISO_RETENTION_EN defined, SAVE and RESTORE SHALL be present as specified.
REQ-034 Without PWR_ISO_RETENTION_EN, PU_WAIT SHALL go directly to ISO_HOLD, ISO_SETUP directly to PD_WAIT, and save/restore SHALL be tied 0.

Structure
REQ-035 Package pwr_iso_pkg SHALL hold the 3-bit state enum and the default cycle constants.
REQ-036 One sub-module, pwr_iso_cnt (loadable down-counter with zero flag), SHALL be shared by the setup, hold and timeout counts.

Verification (ISO_SETUP_CYC=4, ISO_HOLD_CYC=4, ACK_TIMEOUT=16)
REQ-037 Release reset -> iso_en=1, pwr_sw_en=0, busy=0, err=0.
REQ-038 pu_req in OFF, ack 3 cycles after pwr_sw_en rises -> restore pulse, iso_en=0 four cycles later, done pulse.
REQ-039 pd_req in ON -> iso_en=1 next cycle, save pulse after 4 cycles, pwr_sw_en=0, done when ack falls.
REQ-040 Ack withheld in PU_WAIT -> err=1 at cycle 16; late ack completes power-up; err_clr clears err.
REQ-041 pd_req and pu_req together in ON -> power-down; pu_req pulsed during ISO_SETUP -> ignored.
REQ-042 rst_n low during ISO_HOLD -> iso_en=1 and pwr_sw_en=0 immediately, state OFF.

Source files
------------

// File: rtl/pwr_iso_pkg.sv
// Shared types and defaults for the power-domain isolation controller.
// Retention save/restore states are only reachable when PWR_ISO_RETENTION_EN is defined.
package pwr_iso_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_PU_WAIT   = 3'd1,
        ST_RESTORE   = 3'd2,
        ST_ISO_HOLD  = 3'd3,
        ST_ON        = 3'd4,
        ST_ISO_SETUP = 3'd5,
        ST_SAVE      = 3'd6,
        ST_PD_WAIT   = 3'd7
    } pwr_state_e;

    localparam int DEF_ISO_SETUP_CYC = 4;
    localparam int DEF_ISO_HOLD_CYC  = 4;
    localparam int DEF_ACK_TIMEOUT   = 255;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pwr_iso_cnt.sv
// Loadable down-counter with zero flag; saturates at zero.
// One instance is time-shared by the setup, hold and ack-timeout counts.
module pwr_iso_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pwr_iso_ctrl.sv
// Power-gating sequencer: switch, isolation clamps and optional retention pulses.
// Define PWR_ISO_RETENTION_EN to include the SAVE/RESTORE states and pulses.
module pwr_iso_ctrl
    import pwr_iso_pkg::*;
#(
    parameter int ISO_SETUP_CYC = DEF_ISO_SETUP_CYC,
    parameter int ISO_HOLD_CYC  = DEF_ISO_HOLD_CYC,
    parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pu_req,
    input  logic pd_req,
    output logic pwr_sw_en,
    input  logic pwr_sw_ack,
    output logic iso_en,
    output logic save,
    output logic restore,
    output logic busy,
    output logic done,
    output logic err,
    input  logic err_clr
);

    localparam int CW = $clog2(max3(ISO_SETUP_CYC, ISO_HOLD_CYC, ACK_TIMEOUT) + 1);

`ifdef PWR_ISO_RETENTION_EN
    localparam pwr_state_e PU_ACK_NXT   = ST_RESTORE;
    localparam pwr_state_e SETUP_END_NXT = ST_SAVE;
`else
    localparam pwr_state_e PU_ACK_NXT   = ST_ISO_HOLD;
    localparam pwr_state_e SETUP_END_NXT = ST_PD_WAIT;
`endif

    pwr_state_e     state, state_nxt;
    logic           cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0]  cnt_val, cnt;
    logic           to_evt;
    logic           iso_nxt, sw_nxt, busy_nxt, done_nxt, err_nxt;

    pwr_iso_cnt #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_OFF:       if (pu_req)     state_nxt = ST_PU_WAIT;
            ST_PU_WAIT:   if (pwr_sw_ack) state_nxt = PU_ACK_NXT;
            ST_RESTORE:                   state_nxt = ST_ISO_HOLD;
            ST_ISO_HOLD:  if (cnt_zero)   state_nxt = ST_ON;
            ST_ON:        if (pd_req)     state_nxt = ST_ISO_SETUP;
            ST_ISO_SETUP: if (cnt_zero)   state_nxt = SETUP_END_NXT;
            ST_SAVE:                      state_nxt = ST_PD_WAIT;
            ST_PD_WAIT:   if (!pwr_sw_ack) state_nxt = ST_OFF;
            default:                      state_nxt = ST_OFF;
        endcase
    end

    // Timeout is loaded with the full count so it fires once, on the cycle the
    // last wait cycle elapses; afterwards the counter sits at zero.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        if (state_nxt != state) begin
            case (state_nxt)
                ST_PU_WAIT, ST_PD_WAIT: begin cnt_load = 1'b1; cnt_val = CW'(ACK_TIMEOUT);       end
                ST_ISO_HOLD:            begin cnt_load = 1'b1; cnt_val = CW'(ISO_HOLD_CYC - 1);  end
                ST_ISO_SETUP:           begin cnt_load = 1'b1; cnt_val = CW'(ISO_SETUP_CYC - 1); end
                default:                ;
            endcase
        end else begin
            cnt_dec = !cnt_zero;
        end
    end

    always_comb begin
        to_evt   = (((state == ST_PU_WAIT) && !pwr_sw_ack) ||
                    ((state == ST_PD_WAIT) &&  pwr_sw_ack)) && (cnt == CW'(1));
        iso_nxt  = (state_nxt != ST_ON);
        sw_nxt   = !((state_nxt == ST_OFF) || (state_nxt == ST_PD_WAIT));
        busy_nxt = !((state_nxt == ST_OFF) || (state_nxt == ST_ON));
        done_nxt = ((state_nxt == ST_OFF) || (state_nxt == ST_ON)) && (state_nxt != state);
        err_nxt  = to_evt ? 1'b1 : (err_clr ? 1'b0 : err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_OFF;
        else
            state <= state_nxt;
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iso_en    <= 1'b1;
            pwr_sw_en <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            iso_en    <= iso_nxt;
            pwr_sw_en <= sw_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
        end
    end

`ifdef PWR_ISO_RETENTION_EN
    logic save_q, restore_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            save_q    <= 1'b0;
            restore_q <= 1'b0;
        end else begin
            save_q    <= (state_nxt == ST_SAVE);
            restore_q <= (state_nxt == ST_RESTORE);
        end
    end

    assign save    = save_q;
    assign restore = restore_q;
`else
    assign save    = 1'b0;
    assign restore = 1'b0;
`endif

    a_iso_when_off: assert property (@(posedge clk) disable iff (!rst_n) (!pwr_sw_en |-> iso_en));

endmodule

// File: tb/tb_pwr_iso_ctrl.sv
// Self-checking bench for pwr_iso_ctrl: randomized ack timing/requests against a timeline model.
module tb_pwr_iso_ctrl;

    localparam int SETUP = 4;
    localparam int HOLD  = 4;
    localparam int TO    = 16;
`ifdef PWR_ISO_RETENTION_EN
    localparam int RET = 1;
`else
    localparam int RET = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pu_req = 1'b0, pd_req = 1'b0, pwr_sw_ack = 1'b0, err_clr = 1'b0;
    logic pwr_sw_en, iso_en, save, restore, busy, done, err;
    logic [6:0] obs;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic err_exp = 1'b0;

    pwr_iso_ctrl #(
        .ISO_SETUP_CYC (SETUP),
        .ISO_HOLD_CYC  (HOLD),
        .ACK_TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pu_req     (pu_req),
        .pd_req     (pd_req),
        .pwr_sw_en  (pwr_sw_en),
        .pwr_sw_ack (pwr_sw_ack),
        .iso_en     (iso_en),
        .save       (save),
        .restore    (restore),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    // Bit order: sw iso save restore busy done err
    assign obs = {pwr_sw_en, iso_en, save, restore, busy, done, err};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Power-up from OFF; ack rises d cycles after pwr_sw_en; all expectations
    // are derived from cycle offsets relative to the request.
    task automatic run_up(input int d, input bit rnd, input int clr_at, input string name);
        int ka, kon;
        bit ev;
        logic [6:0] exp;
        ka  = 1 + d;
        kon = ka + 1 + RET + HOLD;
        pu_req     = 1'b1;
        pd_req     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        pwr_sw_ack = 1'b0;
        err_clr    = rnd && ($urandom_range(0, 7) == 0);
        err_exp    = err_clr ? 1'b0 : err_exp;
        step();
        for (int k = 1; k <= kon + 1; k++) begin
            exp = {1'b1, k < kon, 1'b0, (RET == 1) && (k == ka + 1), k < kon, k == kon, err_exp};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL %s k=%0d got %b want %b (sw iso sv rs bsy dn er)", name, k, obs, exp);
            end
            pwr_sw_ack = (k >= ka);
            pu_req     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            pd_req     = (rnd && k < kon) ? 1'($urandom_range(0, 1)) : 1'b0;
            err_clr    = (k == clr_at) || (rnd && ($urandom_range(0, 7) == 0));
            ev         = (k == TO) && (k < ka);
            err_exp    = ev ? 1'b1 : (err_clr ? 1'b0 : err_exp);
            step();
        end
        pu_req  = 1'b0;
        pd_req  = 1'b0;
        err_clr = 1'b0;
        // The final step above lands in a steady ON cycle with err_clr already applied.
    endtask

    // Power-down from ON; ack falls d cycles after pwr_sw_en drops.
    task automatic run_down(input int d, input bit rnd, input bit both, input string name);
        int kpw, ka, koff;
        bit ev;
        logic [6:0] exp;
        kpw  = SETUP + 1 + RET;
        ka   = kpw + d;
        koff = ka + 1;
        pd_req     = 1'b1;
        pu_req     = both ? 1'b1 : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
        pwr_sw_ack = 1'b1;
        err_clr    = rnd && ($urandom_range(0, 7) == 0);
        err_exp    = err_clr ? 1'b0 : err_exp;
        step();
        for (int k = 1; k <= koff + 1; k++) begin
            exp = {k < kpw, 1'b1, (RET == 1) && (k == SETUP + 1), 1'b0, k < koff, k == koff, err_exp};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL %s k=%0d got %b want %b (sw iso sv rs bsy dn er)", name, k, obs, exp);
            end
            pwr_sw_ack = (k < ka);
            pd_req     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            pu_req     = (k < koff) ? ((both && k == 2) || (rnd && 1'($urandom_range(0, 1)))) : 1'b0;
            err_clr    = rnd && ($urandom_range(0, 7) == 0);
            ev         = (k - kpw + 1 == TO) && (k >= kpw) && (k < ka);
            err_exp    = ev ? 1'b1 : (err_clr ? 1'b0 : err_exp);
            step();
        end
        pu_req  = 1'b0;
        pd_req  = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        rst_n = 1'b0;
        repeat (2) step();
        exp = 7'b0100000;
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL reset_held got %b want %b", obs, exp);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL reset_release got %b want %b", obs, exp);
        end
        err_exp = 1'b0;
    endtask

    // Opposite request held in a steady state must not move the controller.
    task automatic test_idle(input bit on_st, input string name);
        logic [6:0] exp;
        pu_req     = !on_st;
        pd_req     = on_st;
        pu_req     = on_st;
        pd_req     = !on_st;
        pwr_sw_ack = on_st;
        for (int i = 0; i < 3; i++) begin
            step();
            exp = {on_st, !on_st, 1'b0, 1'b0, 1'b0, 1'b0, err_exp};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL %s i=%0d got %b want %b", name, i, obs, exp);
            end
        end
        pu_req = 1'b0;
        pd_req = 1'b0;
    endtask

    task automatic test_err_clr();
        n_cmp++;
        if (err !== err_exp) begin
            n_bad++;
            $display("FAIL err_before_clr got %b want %b", err, err_exp);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        err_exp = 1'b0;
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clr got %b want 0", err);
        end
        step();
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_stays_clear got %b want 0", err);
        end
    endtask

    task automatic test_mid_reset();
        logic [6:0] exp;
        pu_req     = 1'b1;
        pwr_sw_ack = 1'b0;
        step();
        pu_req     = 1'b0;
        pwr_sw_ack = 1'b1;
        step();
        repeat (RET + 1) step();
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, err_exp};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL mid_reset_hold got %b want %b", obs, exp);
        end
        #2 rst_n = 1'b0;
        #1;
        exp = 7'b0100000;
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL mid_reset_async got %b want %b", obs, exp);
        end
        err_exp    = 1'b0;
        pwr_sw_ack = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL mid_reset_off i=%0d got %b want %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_up($urandom_range(0, TO + 4), 1'b1, -1, "rand_up");
            run_down($urandom_range(0, TO + 4), 1'b1, 1'b0, "rand_down");
        end
    endtask

    initial begin
        test_reset();
        test_idle(1'b0, "idle_off");
        run_up(3, 1'b0, -1, "power_up");
        test_idle(1'b1, "idle_on");
        run_down($urandom_range(0, 5), 1'b0, 1'b0, "power_down");
        run_up(TO + 3, 1'b0, -1, "timeout_up");
        test_idle(1'b1, "err_sticky");
        test_err_clr();
        run_down(TO + 2, 1'b0, 1'b0, "timeout_down");
        run_up(TO + 2, 1'b0, TO, "clr_collision");
        test_err_clr();
        run_down(2, 1'b0, 1'b1, "both_req");
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
